port_requester: RTL and testbench

//  Requester side of the router arbitration handshake: one instance per router input (L,N,E,W,S).

---
 rtl/router_pkg.sv | 28 ++
 rtl/port_requester_flit_fifo.sv | 49 ++++
 rtl/port_requester.sv | 118 +++++++++++
 tb/tb_port_requester.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Constants shared by the router port requesters and the port arbiter:
// flit type codes, packet length width, port indices and requester states.
package router_pkg;

    localparam logic [2:0] FLIT_HEADER = 3'b001;
    localparam logic [2:0] FLIT_BODY   = 3'b010;
    localparam logic [2:0] FLIT_TAIL   = 3'b100;

    localparam int LEN_W = 12;

    localparam int PORT_L    = 0;
    localparam int PORT_N    = 1;
    localparam int PORT_E    = 2;
    localparam int PORT_W    = 3;
    localparam int PORT_S    = 4;
    localparam int NUM_PORTS = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER
    } req_state_t;

    function automatic logic is_tail(input logic [2:0] id);
        return id == FLIT_TAIL;
    endfunction

endpackage

// File: rtl/port_requester_flit_fifo.sv
// Flit FIFO with wrap-bit pointers and a combinational head, so the head
// flit is visible in the same cycle it becomes the oldest entry.
module flit_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

    // A pop frees the slot the simultaneous push lands in, so full does not block it.
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (rd_en) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end

    assign head = mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/port_requester.sv
// Requester side of the router arbitration handshake: queues flits, requests
// the port arbiter for each packet and streams it to the crossbar while granted.
module port_requester
    import router_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_flit,
    input  logic [2:0]        in_flit_id,
    input  logic              grant,
    input  logic              out_ready,
    output logic              req,
    output logic [2:0]        flit_id,
    output logic [LEN_W-1:0]  length,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_flit,
    output logic              err
);

    req_state_t         state_reg, state_next;
    logic [LEN_W-1:0]   length_reg, length_next;
    logic [LEN_W-1:0]   cnt_reg, cnt_next;
    logic [LEN_W-1:0]   cnt_inc;
    logic [DATA_W+2:0]  head;
    logic [2:0]         head_id;
    logic               empty;
    logic               full;
    logic               pop;
    logic               push;

    // A flit offered while full is still taken when a pop frees a slot that cycle.
    assign push     = in_valid && (!full || pop);
    assign in_ready = !full;

    flit_fifo #(
        .WIDTH (DATA_W + 3),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({in_flit_id, in_flit}),
        .pop       (pop),
        .head      (head),
        .empty     (empty),
        .full      (full)
    );

    assign head_id  = head[DATA_W+2:DATA_W];
    assign out_flit = head[DATA_W-1:0];
    assign flit_id  = empty ? 3'b000 : head_id;
    assign length   = length_reg;
    assign cnt_inc  = cnt_reg + LEN_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            length_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            length_reg <= length_next;
            cnt_reg    <= cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        length_next = length_reg;
        cnt_next    = cnt_reg;
        pop         = 1'b0;
        err         = 1'b0;
        req         = 1'b0;
        out_valid   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!empty) begin
                    if (head_id == FLIT_HEADER) begin
                        length_next = head[LEN_W-1:0];
                        state_next  = ST_REQ;
                    end else begin
                        // Orphan body/tail with no header: discard it.
                        pop = 1'b1;
                        err = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                req = 1'b1;
                if (grant) state_next = ST_XFER;
            end
            ST_XFER: begin
                req       = 1'b1;
                out_valid = grant && !empty;
                if (!grant) begin
                    state_next = ST_REQ;
                end else if (out_valid && out_ready) begin
                    pop = 1'b1;
                    if (is_tail(head_id)) begin
                        err        = (cnt_inc != length_reg);
                        cnt_next   = '0;
                        state_next = ST_IDLE;
                    end else begin
                        err      = (cnt_inc == length_reg);
                        cnt_next = cnt_inc;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_port_requester.sv
// Self-checking bench for port_requester: a queue-based packet model checked
// every cycle, plus directed literal checks per scenario.
module tb_port_requester;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam logic [2:0] HDR  = 3'b001;
    localparam logic [2:0] BODY = 3'b010;
    localparam logic [2:0] TAIL = 3'b100;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_flit;
    logic [2:0]        in_flit_id;
    logic              grant;
    logic              out_ready;
    logic              req;
    logic [2:0]        flit_id;
    logic [11:0]       length;
    logic              out_valid;
    logic [DATA_W-1:0] out_flit;
    logic              err;

    port_requester #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_flit    (in_flit),
        .in_flit_id (in_flit_id),
        .grant      (grant),
        .out_ready  (out_ready),
        .req        (req),
        .flit_id    (flit_id),
        .length     (length),
        .out_valid  (out_valid),
        .out_flit   (out_flit),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pops_seen = 0;
    int errs_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model: queue of buffered flits plus packet progress.
    typedef struct {
        logic [2:0]        id;
        logic [DATA_W-1:0] data;
    } flit_t;

    flit_t       q[$];
    bit          m_active;   // a header has been accepted, packet pending/streaming
    bit          m_stream;   // arbiter has granted this packet and not withdrawn
    logic [11:0] m_sent;
    logic [11:0] m_len;

    always @(negedge clk) begin
        bit          e_pop, e_err, e_valid, n_active, n_stream;
        logic [2:0]  e_fid;
        logic [11:0] n_sent, n_len, inc;
        flit_t       f;
        if (!rst) begin
            q.delete();
            m_active = 0; m_stream = 0; m_sent = '0; m_len = '0;
            chk("rst_req", 32'(req), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_flit_id", 32'(flit_id), 32'd0);
            chk("rst_err", 32'(err), 32'd0);
            chk("rst_length", 32'(length), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
        end else begin
            e_pop = 0; e_err = 0;
            n_active = m_active; n_stream = m_stream; n_sent = m_sent; n_len = m_len;
            e_fid   = (q.size() != 0) ? q[0].id : 3'b000;
            e_valid = m_active && m_stream && grant && (q.size() != 0);
            if (!m_active) begin
                if (q.size() != 0) begin
                    if (q[0].id == HDR) begin
                        n_active = 1; n_stream = 0; n_len = q[0].data[11:0];
                    end else begin
                        e_pop = 1; e_err = 1;
                    end
                end
            end else if (!m_stream) begin
                if (grant) n_stream = 1;
            end else if (!grant) begin
                n_stream = 0;
            end else if (e_valid && out_ready) begin
                e_pop = 1;
                inc = m_sent + 12'd1;
                if (q[0].id == TAIL) begin
                    e_err = (inc != m_len);
                    n_active = 0; n_stream = 0; n_sent = '0;
                end else begin
                    e_err = (inc == m_len);
                    n_sent = inc;
                end
            end
            chk("req", 32'(req), 32'(m_active));
            chk("flit_id", 32'(flit_id), 32'(e_fid));
            chk("out_valid", 32'(out_valid), 32'(e_valid));
            chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
            chk("length", 32'(length), 32'(m_len));
            chk("err", 32'(err), 32'(e_err));
            if (e_valid) chk("out_flit", out_flit, q[0].data);
            if (out_valid && out_ready) begin
                pops_seen++;
                $display("pop  id=%b data=%h", flit_id, out_flit);
            end
            if (err) errs_seen++;
            if (in_valid && (q.size() < DEPTH || e_pop))
                $display("push id=%b data=%h", in_flit_id, in_flit);
            if (e_pop) void'(q.pop_front());
            if (in_valid && (q.size() < DEPTH || e_pop)) begin
                f.id = in_flit_id; f.data = in_flit;
                q.push_back(f);
            end
            m_active = n_active; m_stream = n_stream; m_sent = n_sent; m_len = n_len;
        end
    end

    task automatic push_flit(input logic [2:0] id, input logic [DATA_W-1:0] data);
        in_valid = 1'b1; in_flit_id = id; in_flit = data;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_pops(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (pops_seen >= target) return;
            @(posedge clk); #1;
        end
        chk("pop_timeout", 32'(pops_seen), 32'(target));
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    int base_p, base_e;

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_flit = '0; in_flit_id = '0;
        grant = 1'b0; out_ready = 1'b0;
        idle(3);
        rst = 1'b1;
        idle(1);

        // 1: short packet, arbiter grants immediately
        base_p = pops_seen; base_e = errs_seen;
        grant = 1'b1; out_ready = 1'b1;
        push_flit(HDR, 32'hA000_0003);
        push_flit(BODY, 32'h0000_00B1);
        push_flit(TAIL, 32'h0000_00C1);
        wait_pops(base_p + 3, 20);
        idle(2);
        chk("t1_pops", 32'(pops_seen - base_p), 32'd3);
        chk("t1_errs", 32'(errs_seen - base_e), 32'd0);
        chk("t1_req_low", 32'(req), 32'd0);

        // 2: header waits without grant
        grant = 1'b0;
        push_flit(HDR, 32'h0000_0005);
        idle(10);
        chk("t2_req", 32'(req), 32'd1);
        chk("t2_flit_id", 32'(flit_id), 32'(HDR));
        chk("t2_length", 32'(length), 32'd5);
        chk("t2_out_valid", 32'(out_valid), 32'd0);

        // 3: grant withdrawn after two flits, then resumed
        base_p = pops_seen; base_e = errs_seen;
        push_flit(BODY, 32'h0000_0031);
        push_flit(BODY, 32'h0000_0032);
        push_flit(BODY, 32'h0000_0033);
        push_flit(TAIL, 32'h0000_0034);
        grant = 1'b1;
        wait_pops(base_p + 2, 20);
        grant = 1'b0;
        idle(3);
        chk("t3_req_held", 32'(req), 32'd1);
        chk("t3_out_valid", 32'(out_valid), 32'd0);
        chk("t3_paused_pops", 32'(pops_seen - base_p), 32'd2);
        chk("t3_resume_head", out_flit, 32'h0000_0032);
        grant = 1'b1;
        wait_pops(base_p + 5, 20);
        idle(2);
        chk("t3_pops", 32'(pops_seen - base_p), 32'd5);
        chk("t3_errs", 32'(errs_seen - base_e), 32'd0);

        // 4: full FIFO with simultaneous push and pop
        base_p = pops_seen; base_e = errs_seen;
        grant = 1'b0;
        push_flit(HDR, 32'h0000_000A);
        for (int i = 0; i < 7; i++) push_flit(BODY, 32'h40 + 32'(i));
        chk("t4_full", 32'(in_ready), 32'd0);
        grant = 1'b1;
        idle(1);
        push_flit(BODY, 32'h0000_0047);
        chk("t4_still_full_a", 32'(in_ready), 32'd0);
        push_flit(TAIL, 32'h0000_0048);
        chk("t4_still_full_b", 32'(in_ready), 32'd0);
        wait_pops(base_p + 10, 30);
        idle(2);
        chk("t4_pops", 32'(pops_seen - base_p), 32'd10);
        chk("t4_errs", 32'(errs_seen - base_e), 32'd0);

        // 5: orphan body, short packet, over-long packet
        base_p = pops_seen; base_e = errs_seen;
        push_flit(BODY, 32'h0000_0055);
        idle(1);
        chk("t5_orphan_err", 32'(errs_seen - base_e), 32'd1);
        push_flit(HDR, 32'h0000_0004);
        push_flit(BODY, 32'h0000_0051);
        push_flit(TAIL, 32'h0000_0052);
        push_flit(HDR, 32'h0000_0002);
        push_flit(BODY, 32'h0000_0061);
        push_flit(BODY, 32'h0000_0062);
        push_flit(TAIL, 32'h0000_0063);
        wait_pops(base_p + 7, 40);
        idle(2);
        chk("t5_pops", 32'(pops_seen - base_p), 32'd7);
        chk("t5_errs", 32'(errs_seen - base_e), 32'd4);

        // 6: reset in the middle of a transfer
        base_p = pops_seen;
        push_flit(HDR, 32'h0000_0006);
        push_flit(BODY, 32'h0000_0071);
        push_flit(BODY, 32'h0000_0072);
        push_flit(BODY, 32'h0000_0073);
        wait_pops(base_p + 2, 20);
        chk("t6_busy", 32'(req), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_req_async", 32'(req), 32'd0);
        chk("t6_valid_async", 32'(out_valid), 32'd0);
        chk("t6_fid_async", 32'(flit_id), 32'd0);
        idle(2);
        rst = 1'b1;
        #1;
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        chk("t6_empty", 32'(flit_id), 32'd0);
        idle(3);
        chk("t6_idle_req", 32'(req), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
